// File: rtl/scaling_lut_arbiter.sv
// Round-robin arbiter/sequencer sharing one scaling-coefficient LUT among NUM_REQ requesters.
// Define SCALING_ARB_LAST_HIT_EN to add a last-result cache that bypasses the LUT on repeats.
module scaling_lut_arbiter #(
  parameter int NUM_REQ           = 3,
  parameter int COEFF_WIDTH       = 16,
  parameter int ERROR_SCALE_WIDTH = 32,
  parameter int LUT_LATENCY       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [3*NUM_REQ-1:0]         req_qp_rem,
  input  logic [5*NUM_REQ-1:0]         req_shift,
  input  logic [3*NUM_REQ-1:0]         req_bitdepth,
  output logic [2:0]                   lut_qp_rem,
  output logic [4:0]                   lut_shift,
  output logic [2:0]                   lut_bitdepth,
  output logic                         lut_enable,
  input  logic [COEFF_WIDTH-1:0]       lut_qcoef,
  input  logic [ERROR_SCALE_WIDTH-1:0] lut_errscale,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [COEFF_WIDTH-1:0]       rsp_qcoef,
  output logic [ERROR_SCALE_WIDTH-1:0] rsp_errscale,
  output logic                         rsp_clamped,
  output logic                         busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                       state_q, state_d;
  logic [ID_W-1:0]              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [2:0]                   op_qp_q, op_qp_d;
  logic [4:0]                   op_shift_q, op_shift_d;
  logic [2:0]                   op_bd_q, op_bd_d;
  logic                         op_clamp_q, op_clamp_d;
  logic [ID_W-1:0]              op_id_q, op_id_d;
  logic [ID_W-1:0]              rsp_id_q, rsp_id_d;
  logic [COEFF_WIDTH-1:0]       rsp_qcoef_q, rsp_qcoef_d;
  logic [ERROR_SCALE_WIDTH-1:0] rsp_errscale_q, rsp_errscale_d;
  logic                         rsp_clamped_q, rsp_clamped_d;

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [2:0]      sel_qp_raw, sel_qp, sel_bd;
  logic [4:0]      sel_shift;
  logic            sel_clamp;

  // Search starts just past the previous winner so every requester gets a turn.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[ID_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    sel_qp_raw = '0;
    sel_shift  = '0;
    sel_bd     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_qp_raw = req_qp_rem[3*i +: 3];
        sel_shift  = req_shift[5*i +: 5];
        sel_bd     = req_bitdepth[3*i +: 3];
      end
    end
    sel_clamp = (sel_qp_raw > 3'd5);
    sel_qp    = sel_clamp ? 3'd5 : sel_qp_raw;
  end

`ifdef SCALING_ARB_LAST_HIT_EN
  logic                         cache_valid_q, cache_valid_d;
  logic [2:0]                   cache_qp_q, cache_qp_d;
  logic [4:0]                   cache_shift_q, cache_shift_d;
  logic [2:0]                   cache_bd_q, cache_bd_d;
  logic [COEFF_WIDTH-1:0]       cache_qcoef_q, cache_qcoef_d;
  logic [ERROR_SCALE_WIDTH-1:0] cache_errscale_q, cache_errscale_d;
  logic                         cache_hit;

  assign cache_hit = cache_valid_q && (cache_qp_q == sel_qp) &&
                     (cache_shift_q == sel_shift) && (cache_bd_q == sel_bd);
`endif

  always_comb begin
    // NOTE: every _d starts as its _q (and req_ready as 0) so no branch can infer a latch.
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    op_qp_d        = op_qp_q;
    op_shift_d     = op_shift_q;
    op_bd_d        = op_bd_q;
    op_clamp_d     = op_clamp_q;
    op_id_d        = op_id_q;
    rsp_id_d       = rsp_id_q;
    rsp_qcoef_d    = rsp_qcoef_q;
    rsp_errscale_d = rsp_errscale_q;
    rsp_clamped_d  = rsp_clamped_q;
    req_ready      = '0;
`ifdef SCALING_ARB_LAST_HIT_EN
    cache_valid_d    = cache_valid_q;
    cache_qp_d       = cache_qp_q;
    cache_shift_d    = cache_shift_q;
    cache_bd_d       = cache_bd_q;
    cache_qcoef_d    = cache_qcoef_q;
    cache_errscale_d = cache_errscale_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found && !rst) begin
          req_ready[win_idx] = 1'b1;
          last_grant_d       = win_idx;
          op_id_d            = win_idx;
          op_qp_d            = sel_qp;
          op_shift_d         = sel_shift;
          op_bd_d            = sel_bd;
          op_clamp_d         = sel_clamp;
`ifdef SCALING_ARB_LAST_HIT_EN
          if (cache_hit) begin
            rsp_id_d       = win_idx;
            rsp_qcoef_d    = cache_qcoef_q;
            rsp_errscale_d = cache_errscale_q;
            rsp_clamped_d  = sel_clamp;
            state_d        = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(LUT_LATENCY);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_id_d       = op_id_q;
          rsp_qcoef_d    = lut_qcoef;
          rsp_errscale_d = lut_errscale;
          rsp_clamped_d  = op_clamp_q;
          state_d        = S_RESP;
`ifdef SCALING_ARB_LAST_HIT_EN
          cache_valid_d    = 1'b1;
          cache_qp_d       = op_qp_q;
          cache_shift_d    = op_shift_q;
          cache_bd_d       = op_bd_q;
          cache_qcoef_d    = lut_qcoef;
          cache_errscale_d = lut_errscale;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      cnt_q          <= '0;
      op_qp_q        <= '0;
      op_shift_q     <= '0;
      op_bd_q        <= '0;
      op_clamp_q     <= 1'b0;
      op_id_q        <= '0;
      rsp_id_q       <= '0;
      rsp_qcoef_q    <= '0;
      rsp_errscale_q <= '0;
      rsp_clamped_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      op_qp_q        <= op_qp_d;
      op_shift_q     <= op_shift_d;
      op_bd_q        <= op_bd_d;
      op_clamp_q     <= op_clamp_d;
      op_id_q        <= op_id_d;
      rsp_id_q       <= rsp_id_d;
      rsp_qcoef_q    <= rsp_qcoef_d;
      rsp_errscale_q <= rsp_errscale_d;
      rsp_clamped_q  <= rsp_clamped_d;
    end
  end

`ifdef SCALING_ARB_LAST_HIT_EN
  // NOTE: only the valid bit matters after reset; the payload is reset too to keep outputs defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_q    <= 1'b0;
      cache_qp_q       <= '0;
      cache_shift_q    <= '0;
      cache_bd_q       <= '0;
      cache_qcoef_q    <= '0;
      cache_errscale_q <= '0;
    end else begin
      cache_valid_q    <= cache_valid_d;
      cache_qp_q       <= cache_qp_d;
      cache_shift_q    <= cache_shift_d;
      cache_bd_q       <= cache_bd_d;
      cache_qcoef_q    <= cache_qcoef_d;
      cache_errscale_q <= cache_errscale_d;
    end
  end
`endif

  // LUT operands come straight from the latched registers so they cannot move mid-lookup.
  assign lut_qp_rem   = op_qp_q;
  assign lut_shift    = op_shift_q;
  assign lut_bitdepth = op_bd_q;
  assign lut_enable   = (state_q == S_ISSUE);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_qcoef    = rsp_qcoef_q;
  assign rsp_errscale = rsp_errscale_q;
  assign rsp_clamped  = rsp_clamped_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_scaling_lut_arbiter.sv
// Self-checking bench for scaling_lut_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level model and a stand-in LUT with real latency.
module tb_scaling_lut_arbiter;
  localparam int N   = 3;
  localparam int CW  = 16;
  localparam int EW  = 32;
  localparam int LAT = 2;
  localparam int IDW = $clog2(N);
`ifdef SCALING_ARB_LAST_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [3*N-1:0] req_qp_rem = '0;
  logic [5*N-1:0] req_shift = '0;
  logic [3*N-1:0] req_bitdepth = '0;
  logic [2:0]    lut_qp_rem;
  logic [4:0]    lut_shift;
  logic [2:0]    lut_bitdepth;
  logic          lut_enable;
  logic [CW-1:0] lut_qcoef;
  logic [EW-1:0] lut_errscale;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [CW-1:0] rsp_qcoef;
  logic [EW-1:0] rsp_errscale;
  logic          rsp_clamped;
  logic          busy;

  always #5 clk = ~clk;

  scaling_lut_arbiter #(
    .NUM_REQ(N), .COEFF_WIDTH(CW), .ERROR_SCALE_WIDTH(EW), .LUT_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_qp_rem(req_qp_rem), .req_shift(req_shift), .req_bitdepth(req_bitdepth),
    .lut_qp_rem(lut_qp_rem), .lut_shift(lut_shift), .lut_bitdepth(lut_bitdepth),
    .lut_enable(lut_enable), .lut_qcoef(lut_qcoef), .lut_errscale(lut_errscale),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_qcoef(rsp_qcoef), .rsp_errscale(rsp_errscale), .rsp_clamped(rsp_clamped),
    .busy(busy)
  );

  // Stand-in LUT: HM quant scales for the coefficient, a made-up mix for the error scale
  // that gives 8 for (qp=4, shift=0, bitdepth=0). Outputs are junk until LAT cycles after enable.
  function automatic logic [CW-1:0] ref_qcoef(input logic [2:0] qp);
    case (qp)
      3'd0: return 16'd26214;
      3'd1: return 16'd23302;
      3'd2: return 16'd20560;
      3'd3: return 16'd18396;
      3'd4: return 16'd16384;
      3'd5: return 16'd14564;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [EW-1:0] ref_errscale(input logic [2:0] qp, input logic [4:0] sh,
                                                 input logic [2:0] bd);
    return (32'd8 << sh[3:0]) ^ (32'(bd) << 20) ^ (32'(qp ^ 3'd4) << 24);
  endfunction

  int lut_age;
  logic lut_ok;
  always @(posedge clk or posedge rst) begin
    if (rst) lut_age <= 0;
    else if (lut_enable) lut_age <= 1;
    else if (lut_age != 0 && lut_age < 1000) lut_age <= lut_age + 1;
  end
  always_comb begin
    lut_ok       = !lut_enable && (lut_age >= LAT);
    lut_qcoef    = lut_ok ? ref_qcoef(lut_qp_rem) : 16'hBAD0;
    lut_errscale = lut_ok ? ref_errscale(lut_qp_rem, lut_shift, lut_bitdepth) : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding job with an accept cycle and a response cycle.
  int            cyc = 0;
  logic [N-1:0]  g_mask;
  logic [N-1:0]  obs_ready;
  int            m_last;
  bit            m_busy, m_hit, m_cache_upd;
  int            m_acc, m_rsp, m_id;
  logic [2:0]    m_qp, m_bd;
  logic [4:0]    m_sh;
  bit            m_clamp;
  logic [CW-1:0] m_qc;
  logic [EW-1:0] m_es;
  bit            c_valid;
  logic [2:0]    c_qp, c_bd;
  logic [4:0]    c_sh;
  logic [CW-1:0] c_qc;
  logic [EW-1:0] c_es;

  task automatic model_reset();
    m_last  = N - 1;
    m_busy  = 1'b0;
    m_hit   = 1'b0;
    c_valid = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [2:0] qp, input logic [4:0] sh,
                         input logic [2:0] bd);
    req_qp_rem[3*i +: 3]   = qp;
    req_shift[5*i +: 5]    = sh;
    req_bitdepth[3*i +: 3] = bd;
  endtask

  // One clock: score at the falling edge, then return 1ns after the rising edge.
  task automatic tick();
    logic [N-1:0] exp_ready;
    bit           busy_now;
    int           w;
    logic [2:0]   raw;
    @(negedge clk);
    exp_ready = '0;
    g_mask    = '0;
    busy_now  = m_busy;
    obs_ready = req_ready;
    if (!m_busy && req_valid != '0) begin
      w = m_last;
      for (int k = 0; k < N; k++) begin
        w = (w + 1) % N;
        if (req_valid[w]) break;
      end
      raw     = req_qp_rem[3*w +: 3];
      m_clamp = (raw > 3'd5);
      m_qp    = m_clamp ? 3'd5 : raw;
      m_sh    = req_shift[5*w +: 5];
      m_bd    = req_bitdepth[3*w +: 3];
      m_id    = w;
      m_qc    = ref_qcoef(m_qp);
      m_es    = ref_errscale(m_qp, m_sh, m_bd);
      m_hit   = HIT_EN && c_valid && ({c_qp, c_sh, c_bd} == {m_qp, m_sh, m_bd});
      m_acc   = cyc;
      m_rsp   = cyc + (m_hit ? 1 : 2 + LAT);
      m_busy  = 1'b1;
      m_last  = w;
      m_cache_upd  = !m_hit;
      exp_ready[w] = 1'b1;
      g_mask       = exp_ready;
    end
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, busy_now);
    check("lut_enable", lut_enable, busy_now && !m_hit && (cyc == m_acc + 1));
    check("rsp_valid", rsp_valid, busy_now && (cyc >= m_rsp));
    if (busy_now) begin
      check("lut_qp_rem", lut_qp_rem, m_qp);
      check("lut_shift", lut_shift, m_sh);
      check("lut_bitdepth", lut_bitdepth, m_bd);
      if (cyc >= m_rsp) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_qcoef", rsp_qcoef, m_qc);
        check("rsp_errscale", rsp_errscale, m_es);
        check("rsp_clamped", rsp_clamped, m_clamp);
        if (m_cache_upd) begin
          c_valid = 1'b1;
          c_qp = m_qp; c_sh = m_sh; c_bd = m_bd; c_qc = m_qc; c_es = m_es;
          m_cache_upd = 1'b0;
        end
        if (rsp_ready) m_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, '0);
    check({tag, "_lut_qp"}, lut_qp_rem, 3'd0);
    check({tag, "_lut_shift"}, lut_shift, 5'd0);
    check({tag, "_lut_bd"}, lut_bitdepth, 3'd0);
    check({tag, "_lut_en"}, lut_enable, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_id"}, rsp_id, '0);
    check({tag, "_rsp_qcoef"}, rsp_qcoef, '0);
    check({tag, "_rsp_es"}, rsp_errscale, '0);
    check({tag, "_rsp_clamp"}, rsp_clamped, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 300 && (m_busy || req_valid != '0)) begin
      tick();
      req_valid &= ~g_mask;
      k++;
    end
    check("drain_timeout", 64'(m_busy || req_valid != '0), 64'd0);
    check("drain_idle", busy, 1'b0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ord [6];
    int tacc [6];
    int n;
    model_reset();
    #1;
    do_reset("rst0");

    // Single lookup from requester 0.
    rsp_ready = 1'b1;
    set_req(0, 3'd4, 5'd0, 3'd0);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    repeat (1 + LAT) tick();
    check("d1_rsp_valid", rsp_valid, 1'b1);
    check("d1_rsp_id", rsp_id, 0);
    check("d1_qcoef", rsp_qcoef, 16'd16384);
    check("d1_errscale", rsp_errscale, 32'd8);
    check("d1_clamped", rsp_clamped, 1'b0);
    drain();

    // All requesters continuously valid: grant order and accept spacing.
    do_reset("rst1");
    set_req(0, 3'd0, 5'd1, 3'd0);
    set_req(1, 3'd1, 5'd2, 3'd1);
    set_req(2, 3'd2, 5'd3, 3'd2);
    req_valid = 3'b111;
    n = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      tick();
      if (obs_ready != '0) begin
        for (int i = 0; i < N; i++) if (obs_ready[i]) ord[n] = i;
        tacc[n] = cyc - 1;
        n++;
      end
      for (int i = 0; i < N; i++)
        if (g_mask[i]) set_req(i, 3'(i), 5'(10 + n), 3'(i));
    end
    check("rr_count", n, 6);
    for (int k = 0; k < n; k++) begin
      check("rr_order", ord[k], k % N);
      if (k > 0) check("rr_gap", tacc[k] - tacc[k-1], 3 + LAT);
    end
    req_valid = '0;
    drain();

    // Clamped qp_rem from requester 1.
    set_req(1, 3'd7, 5'd3, 3'd1);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    check("clamp_lut_qp", lut_qp_rem, 3'd5);
    repeat (1 + LAT) tick();
    check("clamp_rsp_valid", rsp_valid, 1'b1);
    check("clamp_qcoef", rsp_qcoef, 16'd14564);
    check("clamp_flag", rsp_clamped, 1'b1);
    check("clamp_id", rsp_id, 1);
    drain();

    // Back-pressure in RESP with other requesters waiting.
    rsp_ready = 1'b0;
    set_req(2, 3'd2, 5'd5, 3'd3);
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    set_req(0, 3'd3, 5'd7, 3'd2);
    set_req(1, 3'd0, 5'd9, 3'd4);
    req_valid = 3'b011;
    repeat (1 + LAT) tick();
    repeat (10) tick();
    check("bp_still_valid", rsp_valid, 1'b1);
    check("bp_id", rsp_id, 2);
    rsp_ready = 1'b1;
    drain();

    // Reset during WAIT aborts the lookup; requester 0 wins afterwards.
    set_req(2, 3'd1, 5'd2, 3'd3);
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    tick();
    req_valid = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk);
    #1;
    check("rst_hold_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    model_reset();
    cyc++;
    tick();
    check("post_rst_grant", obs_ready, 3'b001);
    req_valid &= ~g_mask;
    drain();

`ifdef SCALING_ARB_LAST_HIT_EN
    // Repeat of an identical request is served from the cache.
    do_reset("rst_hit");
    set_req(0, 3'd4, 5'd0, 3'd0);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    drain();
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    check("hit_rsp_valid", rsp_valid, 1'b1);
    check("hit_lut_enable", lut_enable, 1'b0);
    check("hit_errscale", rsp_errscale, 32'd8);
    drain();
`endif

    // Randomized traffic: requesters hold until granted, occasionally withdraw.
    for (int c = 0; c < 1500; c++) begin
      tick();
      req_valid &= ~g_mask;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(i, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                    3'($urandom_range(0, 1)));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
